// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: command opcodes, FSM
// states and the opcode-to-{j,k} mapping used when a command is loaded.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Returns {j,k} for a command opcode.
    function automatic logic [1:0] jk_of(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command and drive bundle between a command source and jk_cmd_sequencer.
// Build option: JK_CHECK_EN adds the flop feedback q and the err/err_cnt
// checker outputs.
interface jk_cmd_sequencer_if #(
    parameter int LEN_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
`ifdef JK_CHECK_EN
    logic             q;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_len, q,
        input  cmd_ready, j, k, busy, done, err, err_cnt
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, q,
        output cmd_ready, j, k, busy, done, err, err_cnt
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_len,
        input  cmd_ready, j, k, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len,
        output cmd_ready, j, k, busy, done
    );
`endif
endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO holding {op,len} commands. The head entry is read
// combinationally so the sequencer can load it on the same edge it pops.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_reg[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO and discards queued commands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers HOLD/RESET/SET/TOGGLE commands and replays each as a registered
// j/k pair for max(len,1) cycles, back-to-back with no idle bubble.
// Build option: JK_CHECK_EN adds a reference model of the downstream flop
// and flags cycles where its q disagrees (err sticky, err_cnt saturating).
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    jk_cmd_sequencer_if.slave  bus
);
    localparam int FW = 2 + LEN_W;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             j_reg, j_next;
    logic             k_reg, k_next;
    logic             done_reg, done_next;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    head;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;
    logic [1:0]       head_jk;
    logic [LEN_W-1:0] head_cnt;

    // Ready ignores a same-cycle pop and stays low while reset is held.
    assign bus.cmd_ready = !fifo_full && !reset;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cmd_valid && bus.cmd_ready),
        .wdata ({bus.cmd_op, bus.cmd_len}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op  = head[FW-1:LEN_W];
    assign head_len = head[LEN_W-1:0];
    assign head_jk  = jk_of(head_op);
    // A zero length still drives for one cycle; cnt counts remaining extra cycles.
    assign head_cnt = (head_len == '0) ? '0 : head_len - 1'b1;

    // Next-state: load from the FIFO head when idle or when a command retires.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        done_next  = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    {j_next, k_next} = head_jk;
                    cnt_next         = head_cnt;
                    state_next       = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    done_next = 1'b1;
                    if (!fifo_empty) begin
                        pop              = 1'b1;
                        {j_next, k_next} = head_jk;
                        cnt_next         = head_cnt;
                    end else begin
                        j_next     = 1'b0;
                        k_next     = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                j_next     = 1'b0;
                k_next     = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered j/k/done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            done_reg  <= done_next;
        end
    end

    assign bus.j    = j_reg;
    assign bus.k    = k_reg;
    assign bus.done = done_reg;
    assign bus.busy = (state_reg == ST_DRIVE) || !fifo_empty;

`ifdef JK_CHECK_EN
    logic       exp_q_reg, exp_q_next;
    logic       exp_known_reg, exp_known_next;
    logic       chk_reg;
    logic       err_reg;
    logic [7:0] err_cnt_reg;

    // Reference flop: advances on every cycle the sequencer is driving.
    always_comb begin
        exp_q_next     = exp_q_reg;
        exp_known_next = exp_known_reg;
        if (state_reg == ST_DRIVE) begin
            case ({j_reg, k_reg})
                2'b10: begin
                    exp_q_next     = 1'b1;
                    exp_known_next = 1'b1;
                end
                2'b01: begin
                    exp_q_next     = 1'b0;
                    exp_known_next = 1'b1;
                end
                2'b11:   exp_q_next = ~exp_q_reg;
                default: exp_q_next = exp_q_reg;
            endcase
        end
    end

    // Compare q one cycle after each model update; count saturates at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q_reg     <= 1'b0;
            exp_known_reg <= 1'b0;
            chk_reg       <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            exp_q_reg     <= exp_q_next;
            exp_known_reg <= exp_known_next;
            chk_reg       <= (state_reg == ST_DRIVE);
            if (chk_reg && exp_known_reg && (bus.q != exp_q_reg)) begin
                err_reg <= 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.err     = err_reg;
    assign bus.err_cnt = err_cnt_reg;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: each accepted command pushes its
// expected {j,k}, drive length and whether the next command follows with no
// gap; a monitor measures each drive segment and checks it on every done.
module tb_jk_cmd_sequencer;
    typedef struct {
        logic [1:0] jk;
        int         len;
        bit         follow;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    jk_cmd_sequencer_if #(.LEN_W(8)) ifc ();

    jk_cmd_sequencer #(
        .DEPTH (4),
        .LEN_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

`ifdef JK_CHECK_EN
    logic q_ff;
    logic force_q0 = 1'b0;
    // Behavioural JK flop fed by the sequencer outputs.
    always @(posedge clk or posedge reset) begin
        if (reset) q_ff <= 1'b0;
        else begin
            case ({ifc.j, ifc.k})
                2'b10: q_ff <= 1'b1;
                2'b01: q_ff <= 1'b0;
                2'b11: q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end
    assign ifc.q = force_q0 ? 1'b0 : q_ff;
`endif

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected {j,k} for an opcode: HOLD 00, RESET 01, SET 10, TOGGLE 11.
    function automatic logic [1:0] exp_jk(input logic [1:0] op);
        case (op)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push_cmd(input logic [1:0] op, input int len, input bit follow,
                            input bit expect_it, output int waits);
        logic [7:0] l8;
        exp_t e;
        l8 = len[7:0];
        waits = 0;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_len   = l8;
        while (!ifc.cmd_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (!ifc.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got ready=0 expected ready=1");
            ifc.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (expect_it) begin
            e.jk = exp_jk(op);
            e.len = (len == 0) ? 1 : len;
            e.follow = follow;
            sb.push_back(e);
        end
        $display("push op=%0d len=%0d waits=%0d", op, len, waits);
        #1 ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ifc.busy || sb.size() != 0) && n < 800);
        check("idle_reached", int'(ifc.busy || sb.size() != 0), 0);
        check("idle_jk", int'({ifc.j, ifc.k}), 0);
    endtask

    // Monitor: measures drive segments and retires one expectation per done.
    initial begin : monitor
        int         seg_len;
        logic [1:0] seg_jk;
        bit         seg_bad;
        exp_t       e;
        seg_len = 0;
        seg_jk  = 2'b00;
        seg_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seg_len = 0;
                seg_bad = 1'b0;
            end else begin
                if (ifc.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected done=0");
                    end else begin
                        e = sb.pop_front();
                        $display("done jk=%b len=%0d (exp jk=%b len=%0d)", seg_jk, seg_len, e.jk, e.len);
                        check("seg_len", seg_len, e.len);
                        check("seg_jk", int'(seg_jk), int'(e.jk));
                        check("seg_stable", int'(seg_bad), 0);
                        check("seg_follow", int'(ifc.j | ifc.k), int'(e.follow));
                    end
                    seg_len = 0;
                    seg_bad = 1'b0;
                end
                if (ifc.j | ifc.k) begin
                    if (seg_len == 0) seg_jk = {ifc.j, ifc.k};
                    else if ({ifc.j, ifc.k} != seg_jk) seg_bad = 1'b1;
                    seg_len++;
                end
            end
        end
    end

    initial begin : stimulus
        int w;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'b00;
        ifc.cmd_len   = 8'd0;
        reset = 1'b1;
        #1;
        check("rst_j", int'(ifc.j), 0);
        check("rst_k", int'(ifc.k), 0);
        check("rst_done", int'(ifc.done), 0);
        check("rst_busy", int'(ifc.busy), 0);
        check("rst_ready", int'(ifc.cmd_ready), 0);
`ifdef JK_CHECK_EN
        check("rst_err", int'(ifc.err), 0);
        check("rst_err_cnt", int'(ifc.err_cnt), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", int'(ifc.cmd_ready), 1);

        // Single SET len=3.
        push_cmd(2'b10, 3, 1'b0, 1'b1, w);
        wait_idle();

        // Back-to-back SET 2, TOGGLE 4, RESET 1.
        push_cmd(2'b10, 2, 1'b1, 1'b1, w);
        push_cmd(2'b11, 4, 1'b1, 1'b1, w);
        push_cmd(2'b01, 1, 1'b0, 1'b1, w);
        wait_idle();

        // Fill: A occupies the driver, B..E fill the FIFO, F must wait.
        push_cmd(2'b10, 20, 1'b1, 1'b1, w);
        push_cmd(2'b01, 2, 1'b1, 1'b1, w);
        push_cmd(2'b11, 2, 1'b1, 1'b1, w);
        push_cmd(2'b10, 2, 1'b1, 1'b1, w);
        push_cmd(2'b01, 2, 1'b1, 1'b1, w);
        check("ready_when_full", int'(ifc.cmd_ready), 0);
        push_cmd(2'b11, 3, 1'b0, 1'b1, w);
        check("fifth_wait_cycles", w, 17);
        wait_idle();

        // Length boundaries.
        push_cmd(2'b10, 0, 1'b0, 1'b1, w);
        wait_idle();
        push_cmd(2'b01, 255, 1'b0, 1'b1, w);
        wait_idle();

        // Reset in the middle of a TOGGLE len=10.
        push_cmd(2'b11, 10, 1'b0, 1'b0, w);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_j", int'(ifc.j), 0);
        check("midrst_k", int'(ifc.k), 0);
        check("midrst_busy", int'(ifc.busy), 0);
        check("midrst_ready", int'(ifc.cmd_ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            check("post_rst_quiet", int'({ifc.j, ifc.k, ifc.busy}), 0);
        end

`ifdef JK_CHECK_EN
        // Flop connected: consistent sequence raises no error.
        push_cmd(2'b10, 2, 1'b1, 1'b1, w);
        push_cmd(2'b11, 1, 1'b1, 1'b1, w);
        push_cmd(2'b11, 1, 1'b1, 1'b1, w);
        push_cmd(2'b11, 1, 1'b0, 1'b1, w);
        wait_idle();
        repeat (3) @(negedge clk);
        check("chk_err_clean", int'(ifc.err), 0);
        check("chk_err_cnt_clean", int'(ifc.err_cnt), 0);
        // q stuck at 0 during SET len=3: three mismatching compares.
        force_q0 = 1'b1;
        push_cmd(2'b10, 3, 1'b0, 1'b1, w);
        wait_idle();
        repeat (3) @(negedge clk);
        force_q0 = 1'b0;
        repeat (2) @(negedge clk);
        check("chk_err_set", int'(ifc.err), 1);
        check("chk_err_cnt", int'(ifc.err_cnt), 3);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
